// File: rtl/irq_controller_pkg.sv
// Shared encodings and vector arithmetic for the prioritised interrupt controller.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        TRIG_LVL_HI = 2'b00,
        TRIG_LVL_LO = 2'b01,
        TRIG_RISE   = 2'b10,
        TRIG_FALL   = 2'b11
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_SVC  = 2'b10
    } irq_state_e;

    localparam logic [15:0] VEC_BASE_DEFAULT = 16'h0010;

    // 16-bit modulo vector address; overflow wraps silently.
    function automatic logic [15:0] calc_vector(input logic [15:0] base,
                                                input logic [3:0]  idx,
                                                input int unsigned stride_log2);
        calc_vector = base + ({12'h000, idx} << stride_log2);
    endfunction

endpackage

// File: rtl/irq_controller_src_detect.sv
// Per-source two-flop synchroniser, edge history and pending bit.
module irq_src_detect
    import irq_controller_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       src,
    input  logic [1:0] mode,
    input  logic       ack_clr,
    output logic       pending
);

    logic sync1_r;
    logic sync2_r;
    logic hist_r;
    logic pend_r;
    logic pend_next_s;
    logic rise_s;
    logic fall_s;

    // Synchroniser, edge history and pending register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            sync1_r <= src;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
            pend_r  <= pend_next_s;
        end
    end

    // Pending rule per mode; a fresh edge outranks a same-cycle acknowledge.
    always_comb begin
        rise_s      = sync2_r & ~hist_r;
        fall_s      = ~sync2_r & hist_r;
        pend_next_s = pend_r;
        case (trig_mode_e'(mode))
            TRIG_LVL_HI: pend_next_s = sync2_r;
            TRIG_LVL_LO: pend_next_s = ~sync2_r;
            TRIG_RISE: begin
                if (rise_s)       pend_next_s = 1'b1;
                else if (ack_clr) pend_next_s = 1'b0;
                else              pend_next_s = pend_r;
            end
            TRIG_FALL: begin
                if (fall_s)       pend_next_s = 1'b1;
                else if (ack_clr) pend_next_s = 1'b0;
                else              pend_next_s = pend_r;
            end
            default: pend_next_s = pend_r;
        endcase
    end

    assign pending = pend_r;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: source detectors, fixed-priority encoder,
// request/acknowledge/return sequencer and vector generation.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NUM_SRC         = 16,
    parameter logic [15:0] VEC_BASE        = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE_LOG2 = 2
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic [NUM_SRC-1:0]     irq_src,
    input  logic                   int_enable,
    input  logic [NUM_SRC-1:0]     int_mask,
    input  logic [2*NUM_SRC-1:0]   trig_mode,
    input  logic                   irq_ack,
    input  logic                   reti,
    output logic                   irq_req,
    output logic [15:0]            irq_vector,
    output logic [3:0]             irq_active_id,
    output logic                   in_service,
    output logic [NUM_SRC-1:0]     pending
);

    irq_state_e           state_r;
    irq_state_e           state_next_s;
    logic                 req_r;
    logic                 req_next_s;
    logic [15:0]          vec_r;
    logic [15:0]          vec_next_s;
    logic [3:0]           idx_r;
    logic [3:0]           idx_next_s;
    logic [3:0]           active_r;
    logic [3:0]           active_next_s;
    logic                 svc_r;
    logic                 svc_next_s;
    logic [NUM_SRC-1:0]   pending_s;
    logic [NUM_SRC-1:0]   elig_s;
    logic [NUM_SRC-1:0]   ack_clr_s;
    logic [3:0]           win_idx_s;
    logic                 any_elig_s;
    logic                 ack_s;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_src_detect u_det (
            .clock   (clock),
            .nreset  (nreset),
            .src     (irq_src[g]),
            .mode    (trig_mode[2*g+1:2*g]),
            .ack_clr (ack_clr_s[g]),
            .pending (pending_s[g])
        );
    end

    // Eligibility and lowest-index-wins priority encoder.
    always_comb begin
        elig_s     = pending_s & int_mask & {NUM_SRC{int_enable}};
        any_elig_s = |elig_s;
        win_idx_s  = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig_s[i]) win_idx_s = 4'(i);
            else           win_idx_s = win_idx_s;
        end
    end

    // Acknowledge decode: clears only the edge-pending bit of the registered winner.
    always_comb begin
        ack_s = (state_r == ST_REQ) && irq_ack;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_clr_s[i] = ack_s && (idx_r == 4'(i));
        end
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_next_s  = state_r;
        req_next_s    = req_r;
        vec_next_s    = vec_r;
        idx_next_s    = idx_r;
        active_next_s = active_r;
        svc_next_s    = svc_r;
        case (state_r)
            ST_IDLE: begin
                if (any_elig_s) begin
                    req_next_s   = 1'b1;
                    idx_next_s   = win_idx_s;
                    vec_next_s   = calc_vector(VEC_BASE, win_idx_s, VEC_STRIDE_LOG2);
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    req_next_s    = 1'b0;
                    svc_next_s    = 1'b1;
                    active_next_s = idx_r;
                    state_next_s  = ST_SVC;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_SVC: begin
                if (reti) begin
                    svc_next_s   = 1'b0;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SVC;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                req_next_s   = 1'b0;
                svc_next_s   = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r  <= ST_IDLE;
            req_r    <= 1'b0;
            vec_r    <= 16'h0000;
            idx_r    <= 4'd0;
            active_r <= 4'd0;
            svc_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            req_r    <= req_next_s;
            vec_r    <= vec_next_s;
            idx_r    <= idx_next_s;
            active_r <= active_next_s;
            svc_r    <= svc_next_s;
        end
    end

    assign irq_req       = req_r;
    assign irq_vector    = vec_r;
    assign irq_active_id = active_r;
    assign in_service    = svc_r;
    assign pending       = pending_s;

endmodule

// File: tb/tb_irq_controller.sv
// Scenario bench for irq_controller with an expected-request scoreboard.
module tb_irq_controller;

    logic        clock;
    logic        nreset;
    logic [15:0] irq_src;
    logic        int_enable;
    logic [15:0] int_mask;
    logic [31:0] trig_mode;
    logic        irq_ack;
    logic        reti;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic [3:0]  irq_active_id;
    logic        in_service;
    logic [15:0] pending;

    typedef struct {
        logic [15:0] vec;
        logic [3:0]  id;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   ok;

    irq_controller dut (
        .clock         (clock),
        .nreset        (nreset),
        .irq_src       (irq_src),
        .int_enable    (int_enable),
        .int_mask      (int_mask),
        .trig_mode     (trig_mode),
        .irq_ack       (irq_ack),
        .reti          (reti),
        .irq_req       (irq_req),
        .irq_vector    (irq_vector),
        .irq_active_id (irq_active_id),
        .in_service    (in_service),
        .pending       (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] vec, input logic [3:0] id);
        exp_t e;
        e.vec = vec;
        e.id  = id;
        sb_q.push_back(e);
    endtask

    task automatic pop_exp();
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
        end else begin
            cur.vec = 16'hFFFF;
            cur.id  = 4'hF;
        end
    endtask

    task automatic wait_req(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (irq_req === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #2;
        checks++; if ({irq_req, irq_vector, irq_active_id, in_service, pending} !== 38'd0) begin
            errors++; $display("FAIL reset_outputs: got req=%b vec=%h id=%h svc=%b pend=%h expected all zero",
                               irq_req, irq_vector, irq_active_id, in_service, pending);
        end
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        int_enable = 1'b1;
        int_mask   = 16'h0008;
        irq_src[3] = 1'b1;
        push_exp(16'h001C, 4'd3);
        repeat (3) tick();
        checks++; if (irq_req !== 1'b0) begin
            errors++; $display("FAIL reset_req_early: got %b expected 0", irq_req);
        end
        tick();
        checks++; if (irq_req !== 1'b1) begin
            errors++; $display("FAIL reset_req_rise: got %b expected 1", irq_req);
        end
        pop_exp();
        #2;
        nreset = 1'b0;
        #1;
        checks++; if ({irq_req, in_service, pending} !== 18'd0) begin
            errors++; $display("FAIL reset_async: got req=%b svc=%b pend=%h expected 0", irq_req, in_service, pending);
        end
        irq_src[3] = 1'b0;
        #2;
        nreset = 1'b1;
        repeat (6) tick();
        checks++; if (irq_req !== 1'b0 || pending !== 16'h0000) begin
            errors++; $display("FAIL reset_no_rereq: got req=%b pend=%h expected 0/0000", irq_req, pending);
        end
    endtask

    task automatic test_single_rising();
        irq_src[3] = 1'b1;
        push_exp(16'h001C, 4'd3);
        repeat (2) tick();
        checks++; if (pending[3] !== 1'b0) begin
            errors++; $display("FAIL single_pend_early: got %b expected 0", pending[3]);
        end
        tick();
        checks++; if (pending[3] !== 1'b1 || irq_req !== 1'b0) begin
            errors++; $display("FAIL single_pend: got pend=%b req=%b expected 1/0", pending[3], irq_req);
        end
        tick();
        pop_exp();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL single_req: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (pending[3] !== 1'b0 || in_service !== 1'b1 || irq_active_id !== cur.id || irq_req !== 1'b0) begin
            errors++; $display("FAIL single_ack: got pend=%b svc=%b id=%0d req=%b expected 0/1/%0d/0",
                               pending[3], in_service, irq_active_id, irq_req, cur.id);
        end
        do_reti();
        checks++; if (in_service !== 1'b0) begin
            errors++; $display("FAIL single_reti: got svc=%b expected 0", in_service);
        end
    endtask

    task automatic test_priority();
        int_mask   = 16'hFFFF;
        irq_src[5] = 1'b1;
        irq_src[2] = 1'b1;
        push_exp(16'h0018, 4'd2);
        wait_req(8, ok);
        pop_exp();
        checks++; if (!ok || irq_vector !== cur.vec) begin
            errors++; $display("FAIL prio_vec: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (irq_active_id !== cur.id) begin
            errors++; $display("FAIL prio_id: got %0d expected %0d", irq_active_id, cur.id);
        end
        irq_src[0] = 1'b1;
        push_exp(16'h0010, 4'd0);
        repeat (6) tick();
        checks++; if (irq_req !== 1'b0 || pending[0] !== 1'b1) begin
            errors++; $display("FAIL prio_no_nest: got req=%b pend0=%b expected 0/1", irq_req, pending[0]);
        end
        do_reti();
        tick();
        pop_exp();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL prio_after_reti: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        do_reti();
        push_exp(16'h0024, 4'd5);
        wait_req(4, ok);
        pop_exp();
        checks++; if (!ok || irq_vector !== cur.vec) begin
            errors++; $display("FAIL prio_src5: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (irq_active_id !== cur.id) begin
            errors++; $display("FAIL prio_src5_id: got %0d expected %0d", irq_active_id, cur.id);
        end
        do_reti();
    endtask

    task automatic test_level_low();
        int_mask          = 16'h0000;
        trig_mode[15:14]  = 2'b01;
        repeat (3) tick();
        checks++; if (pending[7] !== 1'b1 || irq_req !== 1'b0) begin
            errors++; $display("FAIL lvl_pend: got pend7=%b req=%b expected 1/0", pending[7], irq_req);
        end
        int_mask = 16'h0080;
        push_exp(16'h002C, 4'd7);
        wait_req(4, ok);
        pop_exp();
        checks++; if (!ok || irq_vector !== cur.vec) begin
            errors++; $display("FAIL lvl_vec: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (pending[7] !== 1'b1 || irq_active_id !== cur.id) begin
            errors++; $display("FAIL lvl_ack: got pend7=%b id=%0d expected 1/%0d", pending[7], irq_active_id, cur.id);
        end
        push_exp(16'h002C, 4'd7);
        do_reti();
        tick();
        pop_exp();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL lvl_rereq: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        irq_src[7] = 1'b1;
        repeat (4) tick();
        checks++; if (pending[7] !== 1'b0) begin
            errors++; $display("FAIL lvl_deassert: got pend7=%b expected 0", pending[7]);
        end
        do_reti();
        repeat (5) tick();
        checks++; if (irq_req !== 1'b0) begin
            errors++; $display("FAIL lvl_no_rereq: got req=%b expected 0", irq_req);
        end
        trig_mode[15:14] = 2'b10;
    endtask

    task automatic test_masking();
        int_mask   = 16'h0000;
        irq_src[1] = 1'b1;
        repeat (4) tick();
        checks++; if (pending[1] !== 1'b1 || irq_req !== 1'b0) begin
            errors++; $display("FAIL mask_pend: got pend1=%b req=%b expected 1/0", pending[1], irq_req);
        end
        int_mask = 16'h0002;
        push_exp(16'h0014, 4'd1);
        tick();
        pop_exp();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL mask_unmask: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        do_reti();
        irq_src[1] = 1'b0;
        repeat (4) tick();
        int_enable = 1'b0;
        irq_src[1] = 1'b1;
        repeat (6) tick();
        checks++; if (pending[1] !== 1'b1 || irq_req !== 1'b0) begin
            errors++; $display("FAIL mask_global_off: got pend1=%b req=%b expected 1/0", pending[1], irq_req);
        end
        int_enable = 1'b1;
        push_exp(16'h0014, 4'd1);
        tick();
        pop_exp();
        int_enable = 1'b0;
        int_mask   = 16'h0000;
        repeat (3) tick();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL mask_hold: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (irq_req !== 1'b0 || pending[1] !== 1'b0 || irq_active_id !== cur.id) begin
            errors++; $display("FAIL mask_hold_ack: got req=%b pend1=%b id=%0d expected 0/0/%0d",
                               irq_req, pending[1], irq_active_id, cur.id);
        end
        do_reti();
        int_enable = 1'b1;
    endtask

    task automatic test_edge_during_ack();
        int_mask   = 16'h0010;
        irq_src[4] = 1'b1;
        push_exp(16'h0020, 4'd4);
        wait_req(8, ok);
        pop_exp();
        checks++; if (!ok || irq_vector !== cur.vec) begin
            errors++; $display("FAIL eack_first: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        irq_src[4] = 1'b0;
        repeat (4) tick();
        irq_src[4] = 1'b1;
        repeat (2) tick();
        do_ack();
        checks++; if (pending[4] !== 1'b1 || in_service !== 1'b1) begin
            errors++; $display("FAIL eack_set_wins: got pend4=%b svc=%b expected 1/1", pending[4], in_service);
        end
        push_exp(16'h0020, 4'd4);
        do_reti();
        tick();
        pop_exp();
        checks++; if (irq_req !== 1'b1 || irq_vector !== cur.vec) begin
            errors++; $display("FAIL eack_rereq: got req=%b vec=%h expected 1/%h", irq_req, irq_vector, cur.vec);
        end
        do_ack();
        checks++; if (pending[4] !== 1'b0 || irq_active_id !== cur.id) begin
            errors++; $display("FAIL eack_clear: got pend4=%b id=%0d expected 0/%0d", pending[4], irq_active_id, cur.id);
        end
        do_reti();
    endtask

    initial begin
        nreset     = 1'b0;
        irq_src    = 16'h0000;
        int_enable = 1'b0;
        int_mask   = 16'h0000;
        trig_mode  = 32'hAAAA_AAAA;
        irq_ack    = 1'b0;
        reti       = 1'b0;
        test_reset();
        test_single_rising();
        test_priority();
        test_level_low();
        test_masking();
        test_edge_during_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
